ika87ad_busmem: RTL and testbench

// - Parametrised external-bus memory responder and clock-enable source for the IKA87AD core.
// - Generates the MCU clock enable from i_EMUCLK and services RD_n/WR_n cycles from a local

---
 rtl/ika87ad_busmem_pkg.sv | 21 ++
 rtl/ika87ad_pcen_gen.sv | 33 +++
 rtl/ika87ad_busmem.sv | 188 ++++++++++++++++++
 tb/tb_ika87ad_busmem.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ika87ad_busmem_pkg.sv
// Shared types and helpers for the IKA87AD external-bus memory responder.
package ika87ad_busmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRIVE = 2'd2
    } rd_state_e;

    localparam int unsigned WCNT_W = 4;

    // Offset is taken modulo 2^16 so a window may wrap past 16'hFFFF.
    function automatic logic addr_in_window(input logic [15:0] addr,
                                            input logic [15:0] base,
                                            input int unsigned aw);
        logic [15:0] off;
        off = addr - base;
        return ({16'h0000, off} < (32'd1 << aw));
    endfunction

endpackage

// File: rtl/ika87ad_pcen_gen.sv
// Free-running prescaler producing a one-EMUCLK-wide clock enable for the core.
module ika87ad_pcen_gen #(
    parameter int unsigned PCEN_DIV = 4
) (
    input  logic i_EMUCLK,
    input  logic i_RESET,
    output logic o_MCUCLK_PCEN
);

    localparam int unsigned CNT_W = (PCEN_DIV > 2) ? $clog2(PCEN_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PCEN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pcen_q, pcen_d;

    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        pcen_d = (cnt_q == LAST);
    end

    always_ff @(posedge i_EMUCLK or posedge i_RESET) begin
        if (i_RESET) begin
            cnt_q  <= '0;
            pcen_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pcen_q <= pcen_d;
        end
    end

    assign o_MCUCLK_PCEN = pcen_q;

endmodule

// File: rtl/ika87ad_busmem.sv
// External-bus memory responder for the IKA87AD core: clock enable, RD/WR servicing
// from a local byte array with wait states, loader port, counters and error flag.
module ika87ad_busmem
    import ika87ad_busmem_pkg::*;
#(
    parameter int unsigned PCEN_DIV = 4,
    parameter int unsigned ADDR_W   = 9,
    parameter logic [15:0] BASE     = 16'h0000,
    parameter int unsigned WAIT_CYC = 0,
    parameter logic [7:0]  FILL     = 8'hFF,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              i_EMUCLK,
    input  logic              i_RESET,
    output logic              o_MCUCLK_PCEN,
    input  logic [15:0]       i_ADDR,
    input  logic              i_RD_n,
    input  logic              i_WR_n,
    input  logic [7:0]        i_DATA,
    output logic [7:0]        o_DATA,
    output logic              o_DATA_OE,
    input  logic              i_LOAD_EN,
    input  logic [ADDR_W-1:0] i_LOAD_ADDR,
    input  logic [7:0]        i_LOAD_DATA,
    output logic [CNT_W-1:0]  o_RD_CNT,
    output logic [CNT_W-1:0]  o_WR_CNT,
    output logic              o_ERR
);

    logic pcen;

    ika87ad_pcen_gen #(
        .PCEN_DIV(PCEN_DIV)
    ) u_pcen_gen (
        .i_EMUCLK     (i_EMUCLK),
        .i_RESET      (i_RESET),
        .o_MCUCLK_PCEN(pcen)
    );

    assign o_MCUCLK_PCEN = pcen;

    logic [ADDR_W-1:0] cur_idx;
    logic              cur_win;

    assign cur_idx = ADDR_W'(i_ADDR - BASE);
    assign cur_win = addr_in_window(i_ADDR, BASE, ADDR_W);

    logic              rd_n_q, wr_n_q;
    rd_state_e         state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] ridx_q, ridx_d;
    logic              rwin_q, rwin_d;
    logic [7:0]        data_q, data_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic              wwin_q, wwin_d;
    logic              wcancel_q, wcancel_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              err_q, err_d;

    logic [7:0] mem [2**ADDR_W];

    logic              capture, rd_done, rd_oow;
    logic [ADDR_W-1:0] fetch_idx;
    logic              fetch_win;
    logic              wr_fall, wr_rise, both_low, cpu_we;

    // Read FSM runs on the registered RD_n history, so acceptance lags the pin by one clock.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        ridx_d    = ridx_q;
        rwin_d    = rwin_q;
        capture   = 1'b0;
        fetch_idx = ridx_q;
        fetch_win = rwin_q;
        rd_done   = 1'b0;
        rd_oow    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rd_n_q) begin
                    ridx_d = cur_idx;
                    rwin_d = cur_win;
                    rd_oow = !cur_win;
                    if (WAIT_CYC == 0) begin
                        state_d   = ST_DRIVE;
                        capture   = 1'b1;
                        fetch_idx = cur_idx;
                        fetch_win = cur_win;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = WCNT_W'(WAIT_CYC);
                    end
                end
            end
            ST_WAIT: begin
                if (rd_n_q) begin
                    state_d = ST_IDLE;
                end else if (pcen) begin
                    if (wcnt_q <= WCNT_W'(1)) begin
                        state_d = ST_DRIVE;
                        capture = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q - 1'b1;
                    end
                end
            end
            ST_DRIVE: begin
                if (rd_n_q) begin
                    state_d = ST_IDLE;
                    rd_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        data_d = capture ? (fetch_win ? mem[fetch_idx] : FILL) : data_q;
    end

    always_comb begin
        both_low  = ~i_RD_n & ~i_WR_n;
        wr_fall   = wr_n_q & ~i_WR_n;
        wr_rise   = ~wr_n_q & i_WR_n;
        widx_d    = widx_q;
        wwin_d    = wwin_q;
        wcancel_d = wcancel_q | both_low;
        wdata_d   = i_WR_n ? wdata_q : i_DATA;
        if (wr_fall) begin
            widx_d    = cur_idx;
            wwin_d    = cur_win;
            wcancel_d = both_low;
        end
        // The loader owns the single write port; a colliding CPU write is lost.
        cpu_we   = wr_rise & wwin_q & ~wcancel_q & ~i_LOAD_EN;
        rd_cnt_d = (rd_done && rd_cnt_q != '1) ? rd_cnt_q + 1'b1 : rd_cnt_q;
        wr_cnt_d = (cpu_we && wr_cnt_q != '1) ? wr_cnt_q + 1'b1 : wr_cnt_q;
        err_d    = err_q | rd_oow | both_low | (wr_fall & ~cur_win);
    end

    always_ff @(posedge i_EMUCLK or posedge i_RESET) begin
        if (i_RESET) begin
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            ridx_q    <= '0;
            rwin_q    <= 1'b0;
            data_q    <= 8'h00;
            widx_q    <= '0;
            wwin_q    <= 1'b0;
            wcancel_q <= 1'b0;
            wdata_q   <= 8'h00;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            rd_n_q    <= i_RD_n;
            wr_n_q    <= i_WR_n;
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            ridx_q    <= ridx_d;
            rwin_q    <= rwin_d;
            data_q    <= data_d;
            widx_q    <= widx_d;
            wwin_q    <= wwin_d;
            wcancel_q <= wcancel_d;
            wdata_q   <= wdata_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_LOAD_EN) begin
            mem[i_LOAD_ADDR] <= i_LOAD_DATA;
        end else if (cpu_we) begin
            mem[widx_q] <= wdata_q;
        end
    end

    assign o_DATA    = data_q;
    assign o_DATA_OE = (state_q == ST_DRIVE) & ~i_RD_n;
    assign o_RD_CNT  = rd_cnt_q;
    assign o_WR_CNT  = wr_cnt_q;
    assign o_ERR     = err_q;

endmodule

// File: tb/tb_ika87ad_busmem.sv
// Randomised bench for ika87ad_busmem: two instances (zero-wait at BASE 0, 3-wait at
// BASE 4000h with 3-bit counters) share one bus and are compared against a byte-array model.
module tb_ika87ad_busmem;

    localparam logic [15:0] BASE_B = 16'h4000;
    localparam int unsigned DEPTH  = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = '0;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic [7:0]  wdata = '0;
    logic        load_en = 1'b0;
    logic [8:0]  load_addr = '0;
    logic [7:0]  load_data = '0;

    logic        pcen_a, pcen_b, oe_a, oe_b, err_a, err_b;
    logic [7:0]  dout_a, dout_b;
    logic [15:0] rdcnt_a, wrcnt_a;
    logic [2:0]  rdcnt_b, wrcnt_b;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned since_rst;

    logic [7:0]  mem_a [DEPTH];
    logic [7:0]  mem_b [DEPTH];
    int unsigned n_rd_a = 0, n_wr_a = 0, n_rd_b = 0, n_wr_b = 0;
    bit          e_a = 1'b0, e_b = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) since_rst <= 0;
        else     since_rst <= since_rst + 1;
    end

    ika87ad_busmem #(
        .PCEN_DIV(4), .ADDR_W(9), .BASE(16'h0000), .WAIT_CYC(0), .FILL(8'hFF), .CNT_W(16)
    ) u_dut_a (
        .i_EMUCLK(clk), .i_RESET(rst), .o_MCUCLK_PCEN(pcen_a),
        .i_ADDR(addr), .i_RD_n(rd_n), .i_WR_n(wr_n), .i_DATA(wdata),
        .o_DATA(dout_a), .o_DATA_OE(oe_a),
        .i_LOAD_EN(load_en), .i_LOAD_ADDR(load_addr), .i_LOAD_DATA(load_data),
        .o_RD_CNT(rdcnt_a), .o_WR_CNT(wrcnt_a), .o_ERR(err_a)
    );

    ika87ad_busmem #(
        .PCEN_DIV(4), .ADDR_W(9), .BASE(BASE_B), .WAIT_CYC(3), .FILL(8'hFF), .CNT_W(3)
    ) u_dut_b (
        .i_EMUCLK(clk), .i_RESET(rst), .o_MCUCLK_PCEN(pcen_b),
        .i_ADDR(addr), .i_RD_n(rd_n), .i_WR_n(wr_n), .i_DATA(wdata),
        .o_DATA(dout_b), .o_DATA_OE(oe_b),
        .i_LOAD_EN(load_en), .i_LOAD_ADDR(load_addr), .i_LOAD_DATA(load_data),
        .o_RD_CNT(rdcnt_b), .o_WR_CNT(wrcnt_b), .o_ERR(err_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic bit in_win(input logic [15:0] a, input logic [15:0] base);
        logic [15:0] off;
        off = a - base;
        return off < 16'd512;
    endfunction

    function automatic int unsigned win_idx(input logic [15:0] a, input logic [15:0] base);
        logic [15:0] off;
        off = a - base;
        return int'(off) % DEPTH;
    endfunction

    function automatic int unsigned sat3(input int unsigned v);
        return (v > 7) ? 7 : v;
    endfunction

    // Clocks from RD_n low (driven just before edge s+1) until OE for the 3-wait instance:
    // the wait starts being evaluated at edge s+3 and ends on the third enable seen there.
    function automatic int unsigned wait_latency(input int unsigned s);
        int unsigned ticks;
        ticks = 0;
        for (int unsigned e = s + 3; e < s + 64; e++) begin
            if ((e - 1) % 4 == 0) begin
                ticks++;
                if (ticks == 3) return e - s;
            end
        end
        return 0;
    endfunction

    task automatic check_pcen();
        check_eq("pcen_a", 32'(pcen_a), 32'(since_rst != 0 && since_rst % 4 == 0));
        check_eq("pcen_b", 32'(pcen_b), 32'(since_rst != 0 && since_rst % 4 == 0));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_pcen();
    endtask

    task automatic check_status();
        check_eq("rd_cnt_a", 32'(rdcnt_a), n_rd_a);
        check_eq("wr_cnt_a", 32'(wrcnt_a), n_wr_a);
        check_eq("rd_cnt_b", 32'(rdcnt_b), sat3(n_rd_b));
        check_eq("wr_cnt_b", 32'(wrcnt_b), sat3(n_wr_b));
        check_eq("err_a", 32'(err_a), 32'(e_a));
        check_eq("err_b", 32'(err_b), 32'(e_b));
    endtask

    task automatic load_byte(input int unsigned idx, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = 9'(idx);
        load_data = d;
        mem_a[idx] = d;
        mem_b[idx] = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input bit with_wr, input bit abort_b, input bit load_mid);
        int unsigned s, lb, hold, ia, ib;
        bit          wa, wb;
        logic [7:0]  exp_a, exp_b, nd;
        s  = since_rst;
        lb = wait_latency(s);
        wa = in_win(a, 16'h0000);
        wb = in_win(a, BASE_B);
        ia = win_idx(a, 16'h0000);
        ib = win_idx(a, BASE_B);
        exp_a = wa ? mem_a[ia] : 8'hFF;
        hold  = abort_b ? 3 + $urandom_range(0, lb - 5) : lb + $urandom_range(0, 3);
        addr = a;
        rd_n = 1'b0;
        if (with_wr) begin
            wr_n  = 1'b0;
            wdata = 8'($urandom);
        end
        for (int unsigned n = 1; n <= hold; n++) begin
            tick();
            check_eq("oe_a", 32'(oe_a), 32'(n >= 2));
            check_eq("oe_b", 32'(oe_b), 32'(n >= lb));
            if (n == 2) check_eq("rdata_a", 32'(dout_a), 32'(exp_a));
            load_en = 1'b0;
            if (load_mid && n == 2) begin
                nd = 8'($urandom);
                load_en   = 1'b1;
                load_addr = 9'(ia);
                load_data = nd;
                mem_a[ia] = nd;
                mem_b[ia] = nd;
            end
        end
        load_en = 1'b0;
        check_eq("rdata_a_held", 32'(dout_a), 32'(exp_a));
        if (!abort_b) begin
            exp_b = wb ? mem_b[ib] : 8'hFF;
            check_eq("rdata_b", 32'(dout_b), 32'(exp_b));
        end
        rd_n = 1'b1;
        wr_n = 1'b1;
        #1;
        check_eq("oe_a_drop", 32'(oe_a), 32'd0);
        check_eq("oe_b_drop", 32'(oe_b), 32'd0);
        n_rd_a++;
        if (!abort_b) n_rd_b++;
        e_a = e_a | !wa | with_wr;
        e_b = e_b | !wb | with_wr;
        repeat (3) tick();
        check_status();
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int unsigned len, input bit conflict);
        bit          wa, wb;
        int unsigned li;
        logic [7:0]  ld;
        wa = in_win(a, 16'h0000);
        wb = in_win(a, BASE_B);
        addr  = a;
        wdata = d;
        wr_n  = 1'b0;
        repeat (len) tick();
        wr_n  = 1'b1;
        wdata = ~d;
        if (conflict) begin
            li = $urandom_range(0, DEPTH - 1);
            ld = 8'($urandom);
            load_en   = 1'b1;
            load_addr = 9'(li);
            load_data = ld;
        end
        tick();
        load_en = 1'b0;
        e_a = e_a | !wa;
        e_b = e_b | !wb;
        if (conflict) begin
            mem_a[li] = ld;
            mem_b[li] = ld;
        end else begin
            if (wa) begin
                mem_a[win_idx(a, 16'h0000)] = d;
                n_wr_a++;
            end
            if (wb) begin
                mem_b[win_idx(a, BASE_B)] = d;
                n_wr_b++;
            end
        end
        tick();
        check_status();
    endtask

    task automatic mid_read_reset(input logic [15:0] a);
        int unsigned lb;
        lb   = wait_latency(since_rst);
        addr = a;
        rd_n = 1'b0;
        repeat (lb) tick();
        check_eq("oe_a_pre_rst", 32'(oe_a), 32'd1);
        check_eq("oe_b_pre_rst", 32'(oe_b), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("oe_a_rst", 32'(oe_a), 32'd0);
        check_eq("oe_b_rst", 32'(oe_b), 32'd0);
        n_rd_a = 0; n_wr_a = 0; n_rd_b = 0; n_wr_b = 0;
        e_a = 1'b0; e_b = 1'b0;
        check_status();
        rd_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_status();
    endtask

    function automatic logic [15:0] pick_addr();
        logic [15:0] edges [8];
        edges = '{16'h01FF, 16'h0200, 16'h3FFF, 16'h41FF, 16'h4200, 16'hFFFF, 16'h0000, 16'h4000};
        case ($urandom % 4)
            0:       return 16'($urandom_range(0, 600));
            1:       return 16'h4000 + 16'($urandom_range(0, 600));
            2:       return 16'($urandom);
            default: return edges[$urandom % 8];
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int unsigned op;
        repeat (3) @(negedge clk);
        check_eq("rst_oe_a", 32'(oe_a), 32'd0);
        check_eq("rst_oe_b", 32'(oe_b), 32'd0);
        check_eq("rst_data_a", 32'(dout_a), 32'h00);
        check_eq("rst_data_b", 32'(dout_b), 32'h00);
        check_eq("rst_pcen_a", 32'(pcen_a), 32'd0);
        check_status();
        rst = 1'b0;
        repeat (16) tick();

        for (int unsigned i = 0; i < DEPTH; i++) load_byte(i, 8'($urandom));
        load_byte(9'h010, 8'hA5);
        load_byte(9'h020, 8'h11);

        do_read(16'h0010, 1'b0, 1'b0, 1'b0);
        do_write(16'h0005, 8'h5A, 2, 1'b0);
        do_read(16'h0005, 1'b0, 1'b0, 1'b0);
        do_read(16'h0020, 1'b1, 1'b0, 1'b0);
        do_read(16'h0020, 1'b0, 1'b0, 1'b0);
        do_write(16'h4001, 8'h3C, 1, 1'b0);
        do_read(16'h4001, 1'b0, 1'b0, 1'b0);
        do_read(16'h0001, 1'b0, 1'b0, 1'b1);
        do_read(16'h41FF, 1'b0, 1'b0, 1'b0);
        do_read(16'h4200, 1'b0, 1'b1, 1'b0);
        do_write(16'h0007, 8'h77, 1, 1'b1);
        do_read(16'h0007, 1'b0, 1'b0, 1'b0);
        mid_read_reset(16'h0010);
        do_read(16'h0010, 1'b0, 1'b0, 1'b0);

        for (int unsigned it = 0; it < 60; it++) begin
            op = $urandom % 8;
            if (op < 4) begin
                do_read(pick_addr(), (op == 3) && ($urandom % 2 == 0),
                        ($urandom % 4 == 0), ($urandom % 3 == 0));
            end else if (op < 7) begin
                do_write(pick_addr(), 8'($urandom), $urandom_range(1, 3), ($urandom % 5 == 0));
            end else begin
                load_byte($urandom_range(0, DEPTH - 1), 8'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
